// File: rtl/adder_acc_if.sv
// adder_acc_if: batch control, operand stream and result stream of adder_accumulator.
interface adder_acc_if #(
    parameter int N  = 8,
    parameter int CW = 4
);
    logic          start;
    logic          inValid;
    logic          inReady;
    logic [N-1:0]  termIn;
    logic          outValid;
    logic          outReady;
    logic [N-1:0]  outSum;
    logic [CW-1:0] outCarryCount;
    logic          busy;

    modport master (
        output start, inValid, termIn, outReady,
        input  inReady, outValid, outSum, outCarryCount, busy
    );

    modport slave (
        input  start, inValid, termIn, outReady,
        output inReady, outValid, outSum, outCarryCount, busy
    );
endinterface

// File: rtl/adder_accumulator.sv
// adder_accumulator: sums a batch of LEN terms and counts carries (saturating at 2^CW-1).
// Optional ADDER_ACC_SATURATE_EN clamps the accumulator to all ones once an add carries.
module adder_accumulator #(
    parameter int N   = 8,
    parameter int LEN = 4,
    parameter int CW  = 4
) (
    input logic         clk,
    input logic         reset,
    adder_acc_if.slave  bus
);
    localparam int TW = (LEN > 1) ? $clog2(LEN) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_acc;
    logic [TW-1:0] r_cnt;
    logic [CW-1:0] r_carry;
    logic          w_xfer;
    logic          w_last;
    logic          w_c;
    logic [N-1:0]  w_add;
    logic [N-1:0]  w_acc_next;

    assign w_xfer       = (r_state == ACCUM) && bus.inValid;
    assign w_last       = r_cnt == TW'(LEN - 1);
    assign {w_c, w_add} = {1'b0, r_acc} + {1'b0, bus.termIn};

`ifdef ADDER_ACC_SATURATE_EN
    assign w_acc_next = w_c ? '1 : w_add;
`else
    assign w_acc_next = w_add;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? ACCUM : IDLE;
            ACCUM:   w_next = (bus.inValid && w_last) ? DONE : ACCUM;
            DONE:    w_next = bus.outReady ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.start) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_carry <= '0;
            end else if (w_xfer) begin
                r_acc   <= w_acc_next;
                r_cnt   <= r_cnt + TW'(1);
                r_carry <= (w_c && r_carry != '1) ? r_carry + CW'(1) : r_carry;
            end
        end
    end

    // Results come straight from the registers so they hold through IDLE until the next start.
    assign bus.inReady       = r_state == ACCUM;
    assign bus.outValid      = r_state == DONE;
    assign bus.busy          = r_state != IDLE;
    assign bus.outSum        = r_acc;
    assign bus.outCarryCount = r_carry;
endmodule

// File: tb/tb_adder_accumulator.sv
// tb_adder_accumulator: random batches on an N=8/LEN=4/CW=4 instance plus a CW=2/LEN=6 saturation instance.
module tb_adder_accumulator;
`ifdef ADDER_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] terms [8];

    always #5 clk = ~clk;

    adder_acc_if #(.N(8), .CW(4)) a ();
    adder_acc_if #(.N(8), .CW(2)) b ();

    adder_accumulator #(.N(8), .LEN(4), .CW(4)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
    adder_accumulator #(.N(8), .LEN(6), .CW(2)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic over the batch.
    function automatic void model(input int n, input int cw, output int s, output int c);
        int x;
        s = 0;
        c = 0;
        for (int i = 0; i < n; i++) begin
            x = s + int'(terms[i]);
            if (x > 255) begin
                c = (c < (1 << cw) - 1) ? c + 1 : c;
                s = SAT ? 255 : x - 256;
            end else begin
                s = x;
            end
        end
    endfunction

    task automatic run_batch(input int gap_max, input int hold);
        int es, ec, g;
        model(4, 4, es, ec);
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        chk("busy_accum", a.busy, 1);
        chk("inready_accum", a.inReady, 1);
        for (int i = 0; i < 4; i++) begin
            g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int k = 0; k < g; k++) begin
                a.inValid = 1'b0;
                a.start = 1'($urandom_range(1, 0));
                tick();
                a.start = 1'b0;
                chk("gap_inready", a.inReady, 1);
                chk("gap_outvalid", a.outValid, 0);
            end
            a.inValid = 1'b1;
            a.termIn = terms[i];
            tick();
            a.inValid = 1'b0;
            chk("outvalid_after_term", a.outValid, (i == 3) ? 1 : 0);
        end
        chk("sum", a.outSum, es);
        chk("carries", a.outCarryCount, ec);
        for (int k = 0; k < hold; k++) begin
            a.start = (k == 1);
            tick();
            a.start = 1'b0;
            chk("hold_outvalid", a.outValid, 1);
            chk("hold_inready", a.inReady, 0);
            chk("hold_sum", a.outSum, es);
            chk("hold_carries", a.outCarryCount, ec);
        end
        a.outReady = 1'b1;
        tick();
        a.outReady = 1'b0;
        chk("idle_outvalid", a.outValid, 0);
        chk("idle_busy", a.busy, 0);
        chk("idle_sum_held", a.outSum, es);
        chk("idle_carries_held", a.outCarryCount, ec);
    endtask

    initial begin
        int es, ec;
        a.start = 1'b0; a.inValid = 1'b0; a.termIn = '0; a.outReady = 1'b0;
        b.start = 1'b0; b.inValid = 1'b0; b.termIn = '0; b.outReady = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_outvalid", a.outValid, 0);
        chk("rst_inready", a.inReady, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_sum", a.outSum, 0);
        chk("rst_carries", a.outCarryCount, 0);

        terms[0] = 8'd10; terms[1] = 8'd20; terms[2] = 8'd30; terms[3] = 8'd40;
        run_batch(0, 0);
        terms[0] = 8'd200; terms[1] = 8'd100; terms[2] = 8'd255; terms[3] = 8'd1;
        run_batch(0, 0);
        terms[0] = 8'd10; terms[1] = 8'd20; terms[2] = 8'd30; terms[3] = 8'd40;
        run_batch(3, 5);
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) terms[i] = 8'($urandom);
            run_batch(2, $urandom_range(3, 0));
        end

        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        a.inValid = 1'b1;
        a.termIn = 8'd77;
        tick();
        tick();
        a.inValid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_outvalid", a.outValid, 0);
        chk("midrst_inready", a.inReady, 0);
        chk("midrst_busy", a.busy, 0);
        chk("midrst_sum", a.outSum, 0);
        chk("midrst_carries", a.outCarryCount, 0);
        terms[0] = 8'd1; terms[1] = 8'd2; terms[2] = 8'd3; terms[3] = 8'd4;
        run_batch(0, 0);

        for (int i = 0; i < 6; i++) terms[i] = 8'd255;
        model(6, 2, es, ec);
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b.inValid = 1'b1;
            b.termIn = terms[i];
            tick();
        end
        b.inValid = 1'b0;
        chk("b_outvalid", b.outValid, 1);
        chk("b_sum", b.outSum, es);
        chk("b_carries_sat", b.outCarryCount, ec);
        b.outReady = 1'b1;
        tick();
        b.outReady = 1'b0;
        chk("b_idle", b.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
